// File: rtl/mux_nway_reg_pkg.sv
// Shared definitions for the N-way registered mux and its round-robin picker.
package mux_nway_reg_pkg;

    typedef enum logic {
        MUX_MODE_DIRECT = 1'b0,
        MUX_MODE_RR     = 1'b1
    } mux_mode_e;

    // Next channel index after idx in an n-entry ring.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_nway_reg_rr_pick.sv
// Combinational rotate-search: first asserted req at or after base, wrapping at N.
module rr_priority_pick
    import mux_nway_reg_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    int idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        // An out-of-range base cannot come from the top, but degrade to a plain priority search.
        idx     = (int'(base) < N) ? int'(base) : 0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(idx);
            end
            idx = rr_next(idx, N);
        end
    end

endmodule

// File: rtl/mux_nway_reg.sv
// N-way W-bit registered mux with per-channel valid/ready, direct or round-robin select.
module mux_nway_reg
    import mux_nway_reg_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 32,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_chan
);

    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

    logic [SELW-1:0] rr_gnt, grant;
    logic            rr_any, grant_ok, load_en, accept;

    rr_priority_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .base    (rr_ptr_q),
        .gnt_idx (rr_gnt),
        .gnt_any (rr_any)
    );

    always_comb begin
        load_en = !out_valid_q || out_ready;
        if (mode == MUX_MODE_RR) begin
            grant    = rr_gnt;
            grant_ok = rr_any;
        end else begin
            grant    = sel;
            grant_ok = (int'(sel) < N) && in_valid[sel];
        end
        // Gate on reset_n so no producer sees a handshake while reset is held.
        accept = reset_n && load_en && grant_ok;

        in_ready = '0;
        if (accept) in_ready[grant] = 1'b1;

        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_data_d  = in_data[int'(grant)*W +: W];
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (mode == MUX_MODE_RR) rr_ptr_d = SELW'(rr_next(int'(grant), N));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: stimulus pushes expected items, a negedge monitor pops and compares.
module tb_mux_nway_reg;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk, reset_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode, out_valid, out_ready;
    logic [1:0]     sel, out_chan;
    logic [W-1:0]   out_data;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  chan;
    } item_t;

    item_t exp_q[$];
    item_t mon_e;
    int    checks = 0;
    int    errors = 0;
    logic  exp_ov = 1'b0;

    mux_nway_reg #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One cycle: drive, check out_valid and in_ready before the edge, record any expected item.
    task automatic step(input logic [3:0] v, input logic md, input logic [1:0] s,
                        input logic ordy, input logic [3:0] exp_rdy,
                        input logic psh, input logic [1:0] ch);
        in_valid  = v;
        mode      = md;
        sel       = s;
        out_ready = ordy;
        #2;
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (psh) exp_q.push_back('{32'hCAFE0000 | 32'(ch), ch});
        exp_ov = psh | (exp_ov & ~ordy);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_item actual=%0h/ch%0d required=none", out_data, out_chan);
            end else begin
                mon_e = exp_q.pop_front();
                chk("item_data", 64'(out_data), 64'(mon_e.data));
                chk("item_chan", 64'(out_chan), 64'(mon_e.chan));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    int rr_seq [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 3, 0, 3, 0};

    initial begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hCAFE0000 | 32'(i);
        reset_n   = 1'b0;
        in_valid  = 4'hF;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;

        // Reset held with every input offering.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        step(4'hF, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0);   // rr_ptr -> 1

        // DIRECT grant, then DIRECT miss drains the output.
        step(4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2);
        step(4'b0100, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd0);
        chk("held_data", 64'(out_data), 64'h0000_0000_CAFE_0002);

        // Round robin resumes from rr_ptr=1 (untouched by DIRECT), then over 4'b1001.
        for (int i = 0; i < 12; i++)
            step((i < 8) ? 4'hF : 4'b1001, 1'b1, 2'd0, 1'b1,
                 4'b0001 << rr_seq[i], 1'b1, 2'(rr_seq[i]));

        // Backpressure: item ch0 must hold, no input handshakes.
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0);
            chk("bp_data", 64'(out_data), 64'h0000_0000_CAFE_0000);
        end
        step(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1);   // drain + accept, rr_ptr -> 2
        step(4'hF, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3);      // DIRECT leaves rr_ptr at 2
        step(4'hF, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2);      // rr_ptr -> 3

        // Async reset between edges while an item is held.
        in_valid  = 4'h0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_data", 64'(out_data), 64'd0);
        in_valid = 4'hF;
        mode     = 1'b1;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        exp_ov = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(4'hF, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0);
        step(4'hF, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1);
        step(4'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0);
        step(4'h0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
